spi_flash_slave: RTL and testbench

SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

---
 rtl/spi_flash_pkg.sv | 15 +
 rtl/spi_flash_slave_if.sv | 11 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_flash_slave.sv | 174 +++++++++++++++++
 tb/tb_spi_flash_slave.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcodes, status bit indices and state types for the SPI flash slave
package spi_flash_pkg;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_READ = 8'h03;

    localparam int ST_WIP = 0;
    localparam int ST_WEL = 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_IGNORE} spi_state_t;
    typedef enum logic [1:0] {P_NONE, P_WREN, P_WRDI, P_BE} pend_t;
endpackage

// File: rtl/spi_flash_slave_if.sv
// rtl/spi_flash_slave_if.sv - SPI bus bundle between flash master and slave
interface spi_flash_slave_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_sck, spi_cs_n, spi_mosi, input spi_miso, spi_miso_oe);
    modport slave  (input spi_sck, spi_cs_n, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/spi_flash_slave.sv
// rtl/spi_flash_slave.sv - SPI mode-0 flash slave model: RDID, RDSR, WREN, WRDI, bulk erase
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] FLASH_ID  = 24'h202015,
    parameter int unsigned BE_CYCLES = 1000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    spi_flash_slave_if.slave spi,
    output logic [7:0]       status,
    output logic             erase_done,
    output logic             cmd_strb,
    output logic [7:0]       cmd_code
);
    localparam logic [19:0] BE_LOAD = 20'(BE_CYCLES);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.sys_clk(sys_clk), .sys_rst(sys_rst), .din(spi.spi_sck),
                                           .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.sys_clk(sys_clk), .sys_rst(sys_rst), .din(spi.spi_cs_n),
                                          .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.sys_clk(sys_clk), .sys_rst(sys_rst), .din(spi.spi_mosi),
                                            .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    assign unused_sync = sck_lvl ^ mosi_rise ^ mosi_fall;

    spi_state_t  state, state_next;
    pend_t       pend, pend_dec;
    logic [6:0]  rx;
    logic [5:0]  bit_cnt;
    logic [23:0] tx;
    logic [2:0]  tx_phase;
    logic        resp_sr, miso, miso_oe;
    logic        wip, wel;
    logic [19:0] busy;
    logic [1:0]  age;
    logic        armed;
    logic        sck_rise_sel, sck_fall_sel, last_bit;
    logic [7:0]  opcode;

    assign sck_rise_sel = sck_rise & ~cs_lvl;
    assign sck_fall_sel = sck_fall & ~cs_lvl;
    assign last_bit     = sck_rise_sel && (bit_cnt == 6'd7);
    assign opcode       = {rx, mosi_lvl};

    always_comb begin
        status         = 8'h00;
        status[ST_WIP] = wip;
        status[ST_WEL] = wel;
    end
    assign spi.spi_miso    = miso;
    assign spi.spi_miso_oe = miso_oe;

    always_comb begin
        pend_dec = P_NONE;
        case (opcode)
            OP_WREN: pend_dec = P_WREN;
            OP_WRDI: pend_dec = P_WRDI;
            OP_BE:   pend_dec = P_BE;
            default: pend_dec = P_NONE;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (cs_fall && armed) state_next = S_CMD;
            S_CMD: begin
                if (last_bit) begin
                    if (opcode == OP_RDSR || (opcode == OP_RDID && !wip)) state_next = S_RESP;
                    else                                                  state_next = S_IGNORE;
                end
            end
            default: state_next = state;
        endcase
        if (cs_rise) state_next = S_IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend       <= P_NONE;
            rx         <= '0;
            bit_cnt    <= '0;
            tx         <= '0;
            tx_phase   <= '0;
            resp_sr    <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            wip        <= 1'b0;
            wel        <= 1'b0;
            busy       <= '0;
            erase_done <= 1'b0;
            cmd_strb   <= 1'b0;
            cmd_code   <= 8'h00;
            age        <= '0;
            armed      <= 1'b0;
        end else begin
            cmd_strb   <= 1'b0;
            erase_done <= 1'b0;
            // The synchronizer only reflects the pin two cycles after reset, so wait before trusting cs_n high.
            if (age != 2'd3) age <= age + 2'd1;
            if (age == 2'd3 && cs_lvl) armed <= 1'b1;

            if (state == S_IDLE && state_next == S_CMD) begin
                bit_cnt <= '0;
                rx      <= '0;
            end else if (state != S_IDLE && sck_rise_sel) begin
                rx <= {rx[5:0], mosi_lvl};
                if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end

            if (state == S_CMD && last_bit) begin
                cmd_code <= opcode;
                cmd_strb <= 1'b1;
                pend     <= pend_dec;
                resp_sr  <= (opcode == OP_RDSR);
                tx       <= FLASH_ID;
                tx_phase <= '0;
            end

            // RDSR reloads live status at every byte boundary so polling sees WIP clear.
            if (state == S_RESP && sck_fall_sel) begin
                tx_phase <= tx_phase + 3'd1;
                if (resp_sr && tx_phase == 3'd0) begin
                    miso <= status[7];
                    tx   <= {status[6:0], 17'd0};
                end else begin
                    miso <= tx[23];
                    tx   <= {tx[22:0], 1'b0};
                end
            end

            miso_oe <= (state_next == S_RESP);

            if (wip) begin
                if (busy == 20'd1) begin
                    wip        <= 1'b0;
                    wel        <= 1'b0;
                    erase_done <= 1'b1;
                    busy       <= '0;
                end else begin
                    busy <= busy - 20'd1;
                end
            end

            if (cs_rise && state != S_IDLE) begin
                miso <= 1'b0;
                pend <= P_NONE;
                if (bit_cnt == 6'd8 && !wip) begin
                    case (pend)
                        P_WREN: wel <= 1'b1;
                        P_WRDI: wel <= 1'b0;
                        P_BE: begin
                            if (wel) begin
                                wip  <= 1'b1;
                                busy <= BE_LOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_slave.sv
// tb/tb_spi_flash_slave.sv - directed self-checking bench for spi_flash_slave
module tb_spi_flash_slave;
    import spi_flash_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] status, cmd_code;
    logic       erase_done, cmd_strb;

    spi_flash_slave_if spi ();

    spi_flash_slave #(.FLASH_ID(24'h202015), .BE_CYCLES(100)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .spi       (spi.slave),
        .status    (status),
        .erase_done(erase_done),
        .cmd_strb  (cmd_strb),
        .cmd_code  (cmd_code)
    );

    always #10 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, strb_cnt = 0, ed_cnt = 0, t_wip = 0, t_ed = 0;
    logic wip_q = 1'b0;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (cmd_strb) strb_cnt <= strb_cnt + 1;
        if (erase_done) begin
            ed_cnt <= ed_cnt + 1;
            t_ed   <= cyc;
        end
        if (status[0] && !wip_q) t_wip <= cyc;
        wip_q <= status[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic cs_low();
        spi.spi_cs_n = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic cs_high();
        half();
        spi.spi_cs_n = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1;
    endtask

    // MISO is sampled at the end of the high phase: the slave's synchronizer delay exceeds half an SCK period.
    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] q);
        logic [7:0] sh;
        sh = d;
        q  = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi.spi_mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            half();
            spi.spi_sck = 1'b1;
            half();
            q = {q[6:0], spi.spi_miso};
            spi.spi_sck = 1'b0;
        end
    endtask

    task automatic simple_cmd(input logic [7:0] op);
        logic [7:0] q;
        cs_low();
        spi_bits(op, 8, q);
        cs_high();
    endtask

    initial begin
        logic [7:0] q;
        int strb0, ed0, polls;
        spi.spi_sck  = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        check("rst_status", status, 8'h00);
        check("rst_cmd_code", cmd_code, 8'h00);
        check("rst_miso", spi.spi_miso, 1'b0);
        check("rst_miso_oe", spi.spi_miso_oe, 1'b0);
        check("rst_erase_done", erase_done, 1'b0);
        check("rst_cmd_strb", cmd_strb, 1'b0);
        repeat (10) @(posedge sys_clk);
        #1;

        // RDID
        strb0 = strb_cnt;
        cs_low();
        spi_bits(OP_RDID, 8, q);
        spi_bits(8'h00, 8, q);
        check("rdid_oe", spi.spi_miso_oe, 1'b1);
        check("rdid_b0", q, 8'h20);
        spi_bits(8'h00, 8, q);
        check("rdid_b1", q, 8'h20);
        spi_bits(8'h00, 8, q);
        check("rdid_b2", q, 8'h15);
        spi_bits(8'h00, 8, q);
        check("rdid_tail", q, 8'h00);
        cs_high();
        check("rdid_code", cmd_code, 8'h9F);
        check("rdid_strb", strb_cnt - strb0, 1);
        check("rdid_oe_off", spi.spi_miso_oe, 1'b0);
        check("rdid_miso_off", spi.spi_miso, 1'b0);

        // RDSR after reset
        cs_low();
        spi_bits(OP_RDSR, 8, q);
        spi_bits(8'h00, 8, q);
        check("rdsr_rst", q, 8'h00);
        cs_high();
        check("rdsr_code", cmd_code, 8'h05);

        // WREN then RDSR, two repeated bytes
        simple_cmd(OP_WREN);
        cs_low();
        spi_bits(OP_RDSR, 8, q);
        spi_bits(8'h00, 8, q);
        check("rdsr_wel_b0", q, 8'h02);
        spi_bits(8'h00, 8, q);
        check("rdsr_wel_b1", q, 8'h02);
        cs_high();

        simple_cmd(OP_WRDI);
        check("wrdi_status", status, 8'h00);

        // BE without WREN
        ed0 = ed_cnt;
        simple_cmd(OP_BE);
        repeat (20) @(posedge sys_clk);
        #1;
        check("be_nowel_status", status, 8'h00);
        check("be_nowel_done", ed_cnt - ed0, 0);

        // BE aborted after 5 bits, and BE with 9 bits
        simple_cmd(OP_WREN);
        strb0 = strb_cnt;
        cs_low();
        spi_bits(OP_BE, 5, q);
        cs_high();
        check("be5_strb", strb_cnt - strb0, 0);
        check("be5_status", status, 8'h02);
        cs_low();
        spi_bits(OP_BE, 8, q);
        spi_bits(8'h00, 1, q);
        cs_high();
        repeat (5) @(posedge sys_clk);
        #1;
        check("be9_status", status, 8'h02);

        // Proper bulk erase with RDSR polling
        ed0 = ed_cnt;
        simple_cmd(OP_BE);
        check("be_status", status, 8'h03);
        cs_low();
        spi_bits(OP_RDSR, 8, q);
        spi_bits(8'h00, 8, q);
        check("poll_busy", q, 8'h03);
        polls = 0;
        while (q == 8'h03 && polls < 10) begin
            spi_bits(8'h00, 8, q);
            polls++;
        end
        check("poll_done", q, 8'h00);
        cs_high();
        check("be_final_status", status, 8'h00);
        check("be_done_count", ed_cnt - ed0, 1);
        check("be_done_delay", t_ed - t_wip, 100);

        // Reset mid-erase, with RDID ignored while WIP
        ed0 = ed_cnt;
        simple_cmd(OP_WREN);
        simple_cmd(OP_BE);
        check("be2_status", status, 8'h03);
        cs_low();
        spi_bits(OP_RDID, 8, q);
        repeat (4) @(posedge sys_clk);
        #1;
        check("rdid_busy_oe", spi.spi_miso_oe, 1'b0);
        check("rdid_busy_miso", spi.spi_miso, 1'b0);
        cs_high();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        check("rst_erase_status", status, 8'h00);
        repeat (150) @(posedge sys_clk);
        #1;
        check("rst_erase_done", ed_cnt - ed0, 0);

        // Reset while selected: traffic ignored until cs_n seen high
        strb0 = strb_cnt;
        spi.spi_cs_n = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
        spi_bits(OP_WREN, 8, q);
        cs_high();
        check("rst_cs_strb", strb_cnt - strb0, 0);
        check("rst_cs_status", status, 8'h00);
        simple_cmd(OP_WREN);
        check("rst_cs_wren", status, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
